// File: rtl/iterative_alu_if.sv
// Request/response bundle for iterative_alu.
//   master : execute-stage driver (in_valid, alu_control, src1, src2, out_ready)
//   slave  : the ALU (in_ready, out_valid, alu_result, zero, lt)
// XLEN must match the XLEN of the iterative_alu instance it is bound to.
interface iterative_alu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      alu_control;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result;
  logic            zero;
  logic            lt;

  modport master (
    output in_valid, alu_control, src1, src2, out_ready,
    input  in_ready, out_valid, alu_result, zero, lt
  );

  modport slave (
    input  in_valid, alu_control, src1, src2, out_ready,
    output in_ready, out_valid, alu_result, zero, lt
  );
endinterface

// File: rtl/iterative_alu.sv
// Handshaked integer ALU: RV32I arithmetic/logic/shift/compare in one cycle,
// RV32M multiply/divide iterated over XLEN cycles (shift-add / restoring,
// both on magnitudes with a sign fix-up folded into the final iteration).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   kill   synchronous flush; drops any in-flight op, alu_result kept
//   bus    iterative_alu_if.slave: in_valid/in_ready request with
//          alu_control/src1/src2, out_valid/out_ready response with
//          alu_result/zero/lt (all response fields registered)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | in_ready=1, waiting for a request
// BUSY  | mul/div iterating, cnt_q counts down the remaining iterations
// DONE  | out_valid=1, result held until out_ready
module iterative_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill,
  iterative_alu_if.slave  bus
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8;
  localparam logic [4:0] OP_SLTU = 5'd9;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            lt_q;

  // Iteration context
  logic [SHW-1:0]  cnt_q;
  logic [2:0]      op_q;       // alu_control[2:0]; bit 2 selects divide
  logic            neg_q;      // product / quotient needs negating
  logic            neg_rem_q;  // remainder needs negating (dividend sign)
  logic            lt_cap_q;   // lt of the captured operands
  logic [XLEN-1:0] hi_q;       // mul: upper accumulator, div: partial remainder
  logic [XLEN-1:0] lo_q;       // mul: multiplier / low product, div: dividend / quotient
  logic [XLEN-1:0] opb_q;      // mul: multiplicand magnitude, div: divisor magnitude

  // ---------------- request decode ----------------
  logic [4:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [SHW-1:0]  shamt;
  logic            lt_in;
  logic            is_mdu;
  logic            is_div;
  logic            div_zero;
  logic            div_ovf;
  logic            signed_a;
  logic            signed_b;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] base_res;
  logic [XLEN-1:0] direct_res;

  assign op       = bus.alu_control;
  assign a        = bus.src1;
  assign b        = bus.src2;
  assign shamt    = b[SHW-1:0];
  assign lt_in    = $signed(a) < $signed(b);
  assign is_mdu   = (op[4:3] == 2'b10);
  assign is_div   = is_mdu && op[2];
  assign div_zero = is_div && (b == '0);
  // Only DIV/REM (op[0]==0) are signed and can overflow.
  assign div_ovf  = is_div && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

  // MULH signs both operands, MULHSU only src1; DIV/REM sign both.
  assign signed_a = op[2] ? !op[0] : ((op[1:0] == 2'b01) || (op[1:0] == 2'b10));
  assign signed_b = op[2] ? !op[0] : (op[1:0] == 2'b01);
  assign sign_a   = signed_a && a[XLEN-1];
  assign sign_b   = signed_b && b[XLEN-1];
  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  assign mag_a    = sign_a ? -a : a;
  assign mag_b    = sign_b ? -b : b;

  always_comb begin
    base_res = '0;
    case (op)
      OP_ADD:  base_res = a + b;
      OP_SUB:  base_res = a - b;
      OP_AND:  base_res = a & b;
      OP_OR:   base_res = a | b;
      OP_XOR:  base_res = a ^ b;
      OP_SLL:  base_res = a << shamt;
      OP_SRL:  base_res = a >> shamt;
      OP_SRA:  base_res = $unsigned($signed(a) >>> shamt);
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, lt_in};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (a < b)};
      default: base_res = '0;
    endcase
  end

  // Results that bypass the iteration: base ops, div-by-zero, signed overflow.
  always_comb begin
    direct_res = base_res;
    if (div_zero)
      direct_res = op[1] ? a : '1;
    else if (div_ovf)
      direct_res = op[1] ? '0 : a;
  end

  // ---------------- one iteration ----------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [XLEN-1:0]   step_hi;
  logic [XLEN-1:0]   step_lo;

  assign mul_sum   = {1'b0, hi_q} + ({1'b0, opb_q} & {(XLEN+1){lo_q[0]}});
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  // Partial remainder stays below the divisor, so bit XLEN of the
  // difference is a clean borrow flag.
  assign div_diff  = div_shift - {1'b0, opb_q};

  always_comb begin
    step_hi = hi_q;
    step_lo = lo_q;
    if (op_q[2]) begin
      step_hi = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign fix-up applied to the values produced by the last iteration.
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   iter_res;

  assign prod     = {step_hi, step_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign quot_fix = neg_q ? -step_lo : step_lo;
  assign rem_fix  = neg_rem_q ? -step_hi : step_hi;

  always_comb begin
    iter_res = '0;
    if (op_q[2])
      iter_res = op_q[1] ? rem_fix : quot_fix;
    else if (op_q[1:0] == 2'b00)
      iter_res = prod_fix[XLEN-1:0];
    else
      iter_res = prod_fix[2*XLEN-1:XLEN];
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      lt_q        <= 1'b0;
      cnt_q       <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      neg_rem_q   <= 1'b0;
      lt_cap_q    <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      opb_q       <= '0;
    end else if (kill) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            op_q       <= op[2:0];
            lt_cap_q   <= lt_in;
            if (is_mdu && !div_zero && !div_ovf) begin
              state     <= BUSY;
              cnt_q     <= SHW'(XLEN - 1);
              neg_q     <= sign_a ^ sign_b;
              neg_rem_q <= sign_a;
              hi_q      <= '0;
              lo_q      <= mag_a;
              opb_q     <= mag_b;
            end else begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= direct_res;
              zero_q      <= (direct_res == '0);
              lt_q        <= lt_in;
            end
          end
        end
        BUSY: begin
          hi_q <= step_hi;
          lo_q <= step_lo;
          if (cnt_q == '0) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= iter_res;
            zero_q      <= (iter_res == '0);
            lt_q        <= lt_cap_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.alu_result = result_q;
  assign bus.zero       = zero_q;
  assign bus.lt         = lt_q;
endmodule

// File: tb/tb_iterative_alu.sv
// Directed bench for iterative_alu (XLEN=32): hand-computed vectors for base
// ops, mul/div incl. RISC-V corner cases, latency, hold, kill and async reset.
module tb_iterative_alu;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic kill = 1'b0;

  iterative_alu_if #(.XLEN(XLEN)) bus ();

  iterative_alu #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kill  (kill),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for out_valid. lat counts negedges
  // after the acceptance edge; rdy_seen records any in_ready high meanwhile.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic rdy_seen);
    int guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.in_valid    = 1'b1;
    bus.alu_control = op;
    bus.src1        = a;
    bus.src2        = b;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.src1     = ~a;
    bus.src2     = a ^ b ^ 32'h5A5A_A5A5;
    lat      = 1;
    rdy_seen = bus.in_ready;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
      rdy_seen = rdy_seen | bus.in_ready;
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input logic exp_lt);
    int   lat;
    logic rdy_seen;
    issue(op, a, b, lat, rdy_seen);
    check({tag, "_res"}, bus.alu_result, exp);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_zero"}, {31'b0, bus.zero}, {31'b0, (exp == 32'h0)});
    check({tag, "_lt"}, {31'b0, bus.lt}, {31'b0, exp_lt});
    check({tag, "_rdy_busy"}, {31'b0, rdy_seen}, 32'h0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_release"}, {30'b0, bus.out_valid, bus.in_ready}, 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic rdy_seen;
    logic seen;

    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.alu_control = 5'd0;
    bus.src1        = 32'h0;
    bus.src2        = 32'h0;

    repeat (3) @(negedge clk);
    check("reset_outs", {28'b0, bus.out_valid, bus.in_ready, bus.zero, bus.lt}, 32'h6);
    check("reset_res", bus.alu_result, 32'h0);
    rst_n = 1'b1;

    // Base ops (latency 1)
    run_op("add_ovf", 5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1, 1'b0);
    run_op("sub_zero", 5'd1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1, 1'b0);
    run_op("sra",     5'd7,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1, 1'b1);
    run_op("sltu",    5'd9,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1, 1'b0);
    run_op("slt",     5'd8,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b0);
    run_op("op12",    5'd12, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1, 1'b1);
    run_op("xor",     5'd4,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1, 1'b1);
    run_op("sll",     5'd5,  32'h0000_0003, 32'hFFFF_FFE1, 32'h0000_0006, 1, 1'b0);

    // Multiply (latency XLEN+1)
    run_op("mulh",    5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0);
    run_op("mulhu",   5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
    run_op("mul",     5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 1'b0);
    run_op("mulhsu",  5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("mulh_min", 5'd17, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0);

    // Divide
    run_op("div_neg", 5'd20, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, 1'b1);
    run_op("rem_neg", 5'd22, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, 1'b1);
    run_op("div_nd",  5'd20, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0);
    run_op("rem_nd",  5'd22, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0);
    run_op("divu",    5'd21, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33, 1'b0);
    run_op("remu",    5'd23, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33, 1'b0);
    run_op("divu_z",  5'd21, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("remu_z",  5'd23, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1, 1'b0);
    run_op("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
    run_op("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b1);

    // Hold result while out_ready=0; a competing request must not be accepted.
    issue(5'd0, 32'h2, 32'h3, lat, rdy_seen);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid    = 1'b1;
      bus.alu_control = 5'd1;
      bus.src1        = 32'h9;
      bus.src2        = 32'h1;
      @(negedge clk);
      check("hold_res", bus.alu_result, 32'h5);
      check("hold_flags", {28'b0, bus.out_valid, bus.in_ready, bus.zero, bus.lt}, 32'h9);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("hold_release", {30'b0, bus.out_valid, bus.in_ready}, 32'h1);

    // kill together with in_valid suppresses acceptance
    bus.in_valid    = 1'b1;
    bus.alu_control = 5'd0;
    bus.src1        = 32'h11;
    bus.src2        = 32'h22;
    kill            = 1'b1;
    @(negedge clk);
    kill         = 1'b0;
    bus.in_valid = 1'b0;
    check("kill_accept", {30'b0, bus.out_valid, bus.in_ready}, 32'h1);

    // kill at iteration 10 of a DIVU
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.alu_control = 5'd21;
    bus.src1        = 32'd1000;
    bus.src2        = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_state", {30'b0, bus.out_valid, bus.in_ready}, 32'h1);
    check("kill_res_kept", bus.alu_result, 32'h5);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = seen | bus.out_valid;
    end
    check("kill_no_valid", {31'b0, seen}, 32'h0);
    run_op("add_after_kill", 5'd0, 32'd10, 32'd20, 32'd30, 1, 1'b1);

    // Async reset in the middle of a MUL
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.alu_control = 5'd16;
    bus.src1        = 32'h1234;
    bus.src2        = 32'h10;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_outs", {28'b0, bus.out_valid, bus.in_ready, bus.zero, bus.lt}, 32'h6);
    check("areset_res", bus.alu_result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = seen | bus.out_valid;
    end
    check("areset_no_valid", {31'b0, seen}, 32'h0);
    run_op("and_after_rst", 5'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1, 1'b1);
    run_op("mul_after_rst", 5'd16, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 33, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/iterative_alu.md
Name: iterative_alu

Overview:
- Parametrised, handshaked successor to the core's single-cycle integer ALU.
- Executes the full RV32I arithmetic/logic/shift/compare set plus RV32M multiply/divide.
- Base ops complete in one cycle. Multiply and divide run iteratively over XLEN cycles.
- Sits in the execute stage; the pipeline stalls on in_ready/out_valid.

Parameters:
- XLEN, 32, operand/result width (power of two, >= 8).
- SHW, $clog2(XLEN), shift-amount width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- kill  in  1  synchronous abort of any in-flight op (pipeline flush).
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- alu_control  in  5  operation code (see Behaviour).
- src1  in  XLEN  operand A.
- src2  in  XLEN  operand B.
- out_valid  out  1  alu_result/zero/lt are valid.
- out_ready  in  1  consumer takes the result.
- alu_result  out  XLEN  registered result.
- zero  out  1  alu_result == 0.
- lt  out  1  signed src1 < src2 of the accepted op, for branch use.

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Any other code: base-op path, result 0.
- Shifts use src2[SHW-1:0] only. SLT/SLTU produce 0 or 1 zero-extended to XLEN.
- Arithmetic wraps modulo 2^XLEN.
- MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits of the 2*XLEN product:
  - MULH: signed x signed.
  - MULHSU: signed src1 x unsigned src2.
  - MULHU: unsigned x unsigned.
- Division follows RISC-V semantics:
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = src1.
  - Signed overflow (src1 = most negative, src2 = -1): DIV = src1; REM = 0.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: out_valid=0, alu_result=0, zero=1, lt=0, in_ready=1. Iteration counter and internal registers are cleared.
- in_ready = (state==IDLE). A request is accepted on an edge with in_valid && in_ready.
- Operands and opcode are captured at acceptance; later changes to src1/src2 are ignored.
- Base ops, and the div-by-zero and signed-overflow cases: go IDLE->DONE at the acceptance edge. out_valid rises the next cycle (latency 1).
- Mul/div: go IDLE->BUSY at acceptance and run exactly XLEN iterations.
  - Multiply: radix-2 shift-add on magnitudes, with sign fix-up.
  - Divide: restoring, on magnitudes, with sign fix-up.
  - BUSY->DONE on the edge completing iteration XLEN. out_valid is first high XLEN+1 cycles after the acceptance edge.
- lt is computed from the captured operands for every opcode.
- DONE: outputs are held stable while out_valid && !out_ready. When out_ready=1, go to IDLE at that edge; out_valid drops next cycle.
- No accept is possible in DONE, so back-to-back base ops issue every 2 cycles.
- kill: in any state, go to IDLE next edge with out_valid=0. alu_result is left unchanged. A kill in the same cycle as in_valid suppresses acceptance. kill has priority over out_ready.
- Asserting rst_n low mid-operation forces IDLE immediately (asynchronous). No result is produced.
- zero and lt are registered alongside alu_result and change only when entering DONE.

Test Plan:
- Reset, then ADD 0x7FFFFFFF+1 -> out_valid one cycle after accept, result 0x80000000, zero=0, lt=0. SUB 5-5 -> result 0, zero=1.
- SRA 0x80000000 by src2=0x00000024 (shift 4) -> 0xF8000000. SLTU 1 vs 0xFFFFFFFF -> 1. SLT same operands -> 0. Opcode 12 -> result 0.
- MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MUL -> 1. Each op: out_valid exactly 33 cycles after accept, in_ready=0 throughout.
- DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF. DIVU 7/0 -> 0xFFFFFFFF, REMU 7/0 -> 7. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with 1-cycle latency.
- Hold out_ready=0 for 5 cycles after a DONE -> alu_result and flags stable, in_ready=0. Raise out_ready -> in_ready=1 the next cycle.
- kill at iteration 10 of a DIVU -> IDLE next cycle, no out_valid, next ADD correct. Pull rst_n low mid-MUL -> immediate reset values.
